// File: rtl/agat_kbd_scanner_if.sv
// agat_kbd_scanner_if: key-event handshake between the scanner's event FIFO and its consumer.
// The master side presents a show-ahead head entry and the slave side accepts it with ev_ready.
interface agat_kbd_scanner_if #(
    parameter int CODE_W = 7
);
    logic              ev_valid;
    logic [CODE_W-1:0] ev_code;
    logic              ev_release;
    logic              ev_ready;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_release,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_release,
        output ev_ready
    );
endinterface

// File: rtl/agat_kbd_scanner.sv
// agat_kbd_scanner: column-scanned, per-key debounced Agat keyboard matrix with an event FIFO.
// Optional macro AGAT_KBD_RELEASE_EN queues release events too; otherwise releases are silent.
module agat_kbd_scanner #(
    parameter int ROWS       = 16,
    parameter int COLS       = 6,
    parameter int SETTLE     = 4,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int CODE_W     = $clog2(ROWS*COLS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                scan_en,
    output logic [COLS-1:0]     col_n,
    input  logic [ROWS-1:0]     row_n,
    agat_kbd_scanner_if.master  ev,
    output logic                overflow,
    input  logic                clr_ovf,
    output logic                any_key
);
    localparam int NKEYS = ROWS * COLS;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef AGAT_KBD_RELEASE_EN
    localparam int ENTRY_W = CODE_W + 1;
`else
    localparam int ENTRY_W = CODE_W;
`endif

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, NEXT} scan_state_t;

    scan_state_t        scan_state, scan_next;
    logic [COL_W-1:0]   col_idx;
    logic [ROW_W-1:0]   row_idx;
    logic [SET_W-1:0]   settle_cnt;
    logic               settle_done, last_row;

    logic [NKEYS-1:0]   key_state;
    logic [CNT_W-1:0]   key_cnt [NKEYS];

    logic [CODE_W-1:0]  key_idx;
    logic               raw, sampling, disagree, settled;
    logic               cnt_inc, cnt_clr, flip, push_req, push, blocked;
    logic [ENTRY_W-1:0] entry;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     fifo_count;
    logic               fifo_full, fifo_empty, pop;
    logic [ENTRY_W-1:0] head;

    assign settle_done = (settle_cnt == SET_W'(SETTLE - 1));
    assign last_row    = (row_idx == ROW_W'(ROWS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) scan_state <= IDLE;
        else       scan_state <= scan_next;
    end

    always_comb begin
        scan_next = scan_state;
        if (scan_en) begin
            case (scan_state)
                IDLE:    scan_next = DRIVE;
                DRIVE:   if (settle_done) scan_next = SAMPLE;
                SAMPLE:  if (last_row) scan_next = NEXT;
                NEXT:    scan_next = DRIVE;
                default: scan_next = IDLE;
            endcase
        end
    end

    always_comb begin
        col_n = '1;
        if (scan_state == DRIVE || scan_state == SAMPLE) col_n[col_idx] = 1'b0;
    end

    // Position counters advance only with scan_en, so a frozen scan resumes exactly where it stopped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_idx    <= '0;
            row_idx    <= '0;
            settle_cnt <= '0;
        end else if (scan_en) begin
            case (scan_state)
                IDLE: begin
                    col_idx    <= '0;
                    settle_cnt <= '0;
                end
                DRIVE: begin
                    if (settle_done) begin
                        settle_cnt <= '0;
                        row_idx    <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                SAMPLE:  row_idx <= last_row ? '0 : row_idx + ROW_W'(1);
                NEXT: begin
                    col_idx    <= (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + COL_W'(1);
                    settle_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // A transition blocked by a full FIFO leaves state and count alone, so it is retried next scan.
    always_comb begin
        key_idx  = CODE_W'(col_idx) * CODE_W'(ROWS) + CODE_W'(row_idx);
        raw      = ~row_n[row_idx];
        sampling = scan_en && (scan_state == SAMPLE);
        disagree = sampling && (raw != key_state[key_idx]);
        settled  = (32'(key_cnt[key_idx]) >= DEBOUNCE - 1);
        cnt_inc  = disagree && !settled;
`ifdef AGAT_KBD_RELEASE_EN
        push_req = disagree && settled;
        entry    = {key_idx, ~raw};
`else
        push_req = disagree && settled && raw;
        entry    = key_idx;
`endif
        blocked  = push_req && fifo_full;
        push     = push_req && !fifo_full;
        flip     = disagree && settled && !blocked;
        cnt_clr  = (sampling && !disagree) || flip;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_state <= '0;
            for (int i = 0; i < NKEYS; i++) key_cnt[i] <= '0;
        end else begin
            if (flip) key_state[key_idx] <= raw;
            if (cnt_clr)      key_cnt[key_idx] <= '0;
            else if (cnt_inc) key_cnt[key_idx] <= key_cnt[key_idx] + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            any_key  <= 1'b0;
        end else begin
            overflow <= blocked | (overflow & ~clr_ovf);
            any_key  <= |key_state;
        end
    end

    assign fifo_full  = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign pop        = ev.ev_valid && ev.ev_ready;

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

    assign head        = fifo_mem[rd_ptr];
    assign ev.ev_valid = !fifo_empty;
`ifdef AGAT_KBD_RELEASE_EN
    assign ev.ev_code    = ev.ev_valid ? head[ENTRY_W-1:1] : '0;
    assign ev.ev_release = ev.ev_valid & head[0];
`else
    assign ev.ev_code    = ev.ev_valid ? head : '0;
    assign ev.ev_release = 1'b0;
`endif
endmodule
